// File: rtl/instmem_port_arb_pkg.sv
// rtl/instmem_port_arb_pkg.sv - shared defines for the instruction-memory port arbiter
//
// Purpose: pipeline flow-control codes, datapath width and arbiter FSM state encodings.
// Ports:   none (package).
package instmem_port_arb_pkg;

    localparam int CPU_WIDTH  = 32;

    localparam int FLOW_WIDTH = 2;
    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK = 2'd0;
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP = 2'd1;

    localparam int ARB_STATE_WIDTH = 3;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE    = 3'd0,
        ARB_REQ_LS  = 3'd1,
        ARB_REQ_IF  = 3'd2,
        ARB_WAIT_LS = 3'd3,
        ARB_WAIT_IF = 3'd4
    } arb_state_e;

endpackage

// File: rtl/instmem_arb_fsm.sv
// rtl/instmem_arb_fsm.sv - arbitration FSM with load/store run counter and fetch drop flag
//
// Purpose: decides which requester owns the single instruction-memory port and tracks
//          the outstanding access until its response arrives.
// Ports:   clk, rst_n            clock, async active-low reset
//          ls_req_i, if_req_i    requests from load/store and fetch
//          if_flush_i            fetch redirect
//          hold_i                a completion pulse is on the outputs this cycle
//          mem_gnt_i, mem_rvalid_i  memory handshake
//          state_d_o             next state (drives the registered mem_req)
//          start_ls_o/start_if_o IDLE decision this cycle (latch request fields)
//          ls_resp_o/if_resp_o   response to be delivered to the requester
module instmem_arb_fsm
    import instmem_port_arb_pkg::*;
#(
    parameter int MAX_LS_RUN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ls_req_i,
    input  logic       if_req_i,
    input  logic       if_flush_i,
    input  logic       hold_i,
    input  logic       mem_gnt_i,
    input  logic       mem_rvalid_i,
    output arb_state_e state_d_o,
    output logic       start_ls_o,
    output logic       start_if_o,
    output logic       ls_resp_o,
    output logic       if_resp_o
);

    localparam int RUN_W = $clog2(MAX_LS_RUN + 1);

    arb_state_e       state_q, state_d;
    logic [RUN_W-1:0] ls_run_q, ls_run_d;
    logic             drop_q, drop_d;
    logic             run_capped;
    logic             ls_pick;
    logic             if_pick;

    assign run_capped = (ls_run_q == RUN_W'(MAX_LS_RUN));

    // Requesters keep their request high through the completion pulse, so no new
    // decision is taken while a pulse is out; otherwise the finished request would
    // be issued a second time.
    assign ls_pick = (state_q == ARB_IDLE) && !hold_i && ls_req_i
                     && !(run_capped && if_req_i);
    assign if_pick = (state_q == ARB_IDLE) && !hold_i && !ls_pick
                     && if_req_i && !if_flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            ls_run_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ls_run_q <= ls_run_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ls_run_d = ls_run_q;
        drop_d   = drop_q;
        case (state_q)
            ARB_IDLE: begin
                if (ls_pick) begin
                    state_d = ARB_REQ_LS;
                end else if (if_pick) begin
                    state_d = ARB_REQ_IF;
                end
                if (!ls_req_i) begin
                    ls_run_d = '0;
                end
            end
            ARB_REQ_LS: begin
                if (mem_gnt_i) begin
                    state_d = ARB_WAIT_LS;
                end
            end
            ARB_REQ_IF: begin
                // A flush racing the grant cannot cancel an accepted access;
                // its response is discarded instead.
                if (mem_gnt_i) begin
                    state_d = ARB_WAIT_IF;
                    if (if_flush_i) begin
                        drop_d = 1'b1;
                    end
                end else if (if_flush_i) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_LS: begin
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                    if (!run_capped) begin
                        ls_run_d = ls_run_q + 1'b1;
                    end
                end
            end
            ARB_WAIT_IF: begin
                if (mem_rvalid_i) begin
                    state_d  = ARB_IDLE;
                    ls_run_d = '0;
                    drop_d   = 1'b0;
                end else if (if_flush_i) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        state_d_o  = state_d;
        start_ls_o = ls_pick;
        start_if_o = if_pick;
        ls_resp_o  = (state_q == ARB_WAIT_LS) && mem_rvalid_i;
        if_resp_o  = (state_q == ARB_WAIT_IF) && mem_rvalid_i && !drop_q && !if_flush_i;
    end

    rvalid_only_when_waiting_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        mem_rvalid_i |-> (state_q == ARB_WAIT_LS || state_q == ARB_WAIT_IF)
    );

endmodule

// File: rtl/instmem_port_arb.sv
// rtl/instmem_port_arb.sv - instruction-memory port arbiter between fetch and load/store
//
// Purpose: shares the single instruction-memory port between the fetch stage and
//          load/store accesses to the instruction region, returns read data to the
//          winner and stalls both requesters while their access is pending.
// Ports:   clk, rst_n                          clock, async active-low reset
//          if_req_i/if_addr_i/if_flush_i       fetch request, address, redirect
//          if_rdata_o/if_rvalid_o              fetched instruction and its pulse
//          ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_be_i   load/store request
//          ls_rdata_o/ls_done_o                load data and completion pulse
//          mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o  registered memory request
//          mem_gnt_i/mem_rvalid_i/mem_rdata_i  memory handshake and read data
//          flow_if_o/flow_ls_o                 flow codes for fetch and EX/MEM
module instmem_port_arb
    import instmem_port_arb_pkg::*;
#(
    parameter int ADDR_W     = CPU_WIDTH,
    parameter int DATA_W     = CPU_WIDTH,
    parameter int MAX_LS_RUN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    input  logic                  if_flush_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_rvalid_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [ADDR_W-1:0]     ls_addr_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    input  logic [3:0]            ls_be_i,
    output logic [DATA_W-1:0]     ls_rdata_o,
    output logic                  ls_done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic [FLOW_WIDTH-1:0] flow_if_o,
    output logic [FLOW_WIDTH-1:0] flow_ls_o
);

    arb_state_e        fsm_state_d;
    logic              start_ls;
    logic              start_if;
    logic              ls_resp;
    logic              if_resp;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_done_q, ls_done_d;

    instmem_arb_fsm #(
        .MAX_LS_RUN (MAX_LS_RUN)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .ls_req_i     (ls_req_i),
        .if_req_i     (if_req_i),
        .if_flush_i   (if_flush_i),
        .hold_i       (if_rvalid_q | ls_done_q),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .state_d_o    (fsm_state_d),
        .start_ls_o   (start_ls),
        .start_if_o   (start_if),
        .ls_resp_o    (ls_resp),
        .if_resp_o    (if_resp)
    );

    always_comb begin
        // Request is high exactly in the REQ states, so it drops the cycle after gnt
        // or after a flush withdraws a not-yet-granted fetch.
        mem_req_d   = (fsm_state_d == ARB_REQ_LS) || (fsm_state_d == ARB_REQ_IF);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if (start_ls) begin
            mem_we_d    = ls_we_i;
            mem_addr_d  = ls_addr_i;
            mem_wdata_d = ls_wdata_i;
            mem_be_d    = ls_be_i;
        end else if (start_if) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
        end
        if_rvalid_d = if_resp;
        if_rdata_d  = if_resp ? mem_rdata_i : if_rdata_q;
        ls_done_d   = ls_resp;
        // A store ack carries no data; keep the last load result visible.
        ls_rdata_d  = (ls_resp && !mem_we_q) ? mem_rdata_i : ls_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            if_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_done_q   <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_done_q   <= ls_done_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_rvalid_o = if_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_done_o   = ls_done_q;

    // The completion pulse releases the stall in the same cycle it is presented.
    assign flow_ls_o = (ls_req_i && !ls_done_q)   ? FLOW_STOP : FLOW_WORK;
    assign flow_if_o = (if_req_i && !if_rvalid_q) ? FLOW_STOP : FLOW_WORK;

endmodule
